mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for a shared 4-to-1 one-bit multiplexer.

---
 rtl/mux_rr_arbiter_if.sv | 13 +
 rtl/mux_rr_arbiter.sv | 90 +++++++++
 tb/tb_mux_rr_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Bundle between the four requesters and the shared-mux arbiter.
// The requester side drives req/in; the arbiter returns gnt/sel/busy/q.
interface mux_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] in;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       q;

  modport master (output req, output in, input gnt, input sel, input busy, input q);
  modport slave  (input req, input in, output gnt, output sel, output busy, output q);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 one-bit mux.
// Each grant is capped at MAX_HOLD cycles and is followed by one idle cycle.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  mux_rr_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic [3:0]       r_gnt, w_gnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [1:0]       w_winner, w_idx;
  logic             w_release;

  // Scan from ptr upward; the last hit in the reversed loop is the nearest one.
  always_comb begin
    w_winner = r_ptr;
    w_idx    = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (bus.req[w_idx]) w_winner = w_idx;
    end
  end

  assign w_release = !bus.req[r_sel] || (r_hold_cnt == HOLD_LAST);

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_sel_nxt      = r_sel;
    w_gnt_nxt      = r_gnt;
    w_busy_nxt     = r_busy;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_state_nxt    = S_BUSY;
          w_gnt_nxt      = 4'b0001 << w_winner;
          w_sel_nxt      = w_winner;
          w_busy_nxt     = 1'b1;
          w_hold_cnt_nxt = '0;
        end
      end
      S_BUSY: begin
        if (w_release) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = r_sel + 2'd1;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_sel      <= '0;
      r_gnt      <= '0;
      r_busy     <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_sel      <= w_sel_nxt;
      r_gnt      <= w_gnt_nxt;
      r_busy     <= w_busy_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.sel  = r_sel;
  assign bus.busy = r_busy;
  assign bus.q    = r_busy ? bus.in[r_sel] : 1'b0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus randomized traffic against
// a requester-level model, on three instances (MAX_HOLD = 8, 2, 1).
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] tb_req;
  logic [3:0] tb_in;
  int         n_pass  = 0;
  int         n_total = 0;

  mux_rr_arbiter_if bus8();
  mux_rr_arbiter_if bus2();
  mux_rr_arbiter_if bus1();

  assign bus8.req = tb_req;
  assign bus8.in  = tb_in;
  assign bus2.req = tb_req;
  assign bus2.in  = tb_in;
  assign bus1.req = tb_req;
  assign bus1.in  = tb_in;

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
  mux_rr_arbiter #(.MAX_HOLD(2), .CNT_W(1)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
  mux_rr_arbiter #(.MAX_HOLD(1), .CNT_W(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  logic [3:0] o_gnt  [3];
  logic [1:0] o_sel  [3];
  logic       o_busy [3];
  logic       o_q    [3];
  assign o_gnt[0] = bus8.gnt;  assign o_sel[0] = bus8.sel;  assign o_busy[0] = bus8.busy;  assign o_q[0] = bus8.q;
  assign o_gnt[1] = bus2.gnt;  assign o_sel[1] = bus2.sel;  assign o_busy[1] = bus2.busy;  assign o_q[1] = bus2.q;
  assign o_gnt[2] = bus1.gnt;  assign o_sel[2] = bus1.sel;  assign o_busy[2] = bus1.busy;  assign o_q[2] = bus1.q;

  // Requester-level model: who owns the mux, how many cycles it has had it,
  // and which requester has first claim on the next free slot.
  typedef struct {
    int owner;   // -1 when the mux is free
    int len;     // cycles the current owner has been visible
    int ptr;     // first requester considered at the next arbitration
    int sel;     // last requester granted
  } mstate_t;

  localparam int MAXH [3] = '{8, 2, 1};
  mstate_t m [3];

  function automatic mstate_t model_next(input mstate_t s, input logic rst,
                                         input logic [3:0] r, input int maxh);
    mstate_t n;
    bit      found;
    n     = s;
    found = 1'b0;
    if (rst) begin
      n.owner = -1; n.len = 0; n.ptr = 0; n.sel = 0;
    end else if (s.owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (s.ptr + k) % 4;
        if (!found && r[idx]) begin
          found = 1'b1; n.owner = idx; n.sel = idx; n.len = 1;
        end
      end
    end else if (!r[s.owner] || s.len >= maxh) begin
      n.owner = -1;
      n.ptr   = (s.owner + 1) % 4;
    end else begin
      n.len = s.len + 1;
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_gnt(input mstate_t s);
    return (s.owner < 0) ? 4'b0000 : 4'(4'b0001 << s.owner);
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 3; i++) m[i] <= model_next(m[i], reset, tb_req, MAXH[i]);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    tb_req = 4'b0000;
    tick();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    tb_req = 4'b1111;
    tb_in  = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++; if (bus8.gnt !== 4'b0000) $display("FAIL reset_gnt cyc%0d: got %b want 0000", c, bus8.gnt); else n_pass++;
      n_total++; if (bus8.sel !== 2'd0)    $display("FAIL reset_sel cyc%0d: got %0d want 0", c, bus8.sel); else n_pass++;
      n_total++; if (bus8.busy !== 1'b0)   $display("FAIL reset_busy cyc%0d: got %b want 0", c, bus8.busy); else n_pass++;
      n_total++; if (bus8.q !== 1'b0)      $display("FAIL reset_q cyc%0d: got %b want 0", c, bus8.q); else n_pass++;
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    tb_in  = 4'b0100;
    tb_req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++; if (bus8.gnt !== 4'b0100) $display("FAIL single_gnt cyc%0d: got %b want 0100", c, bus8.gnt); else n_pass++;
      n_total++; if (bus8.sel !== 2'd2)    $display("FAIL single_sel cyc%0d: got %0d want 2", c, bus8.sel); else n_pass++;
      n_total++; if (bus8.q !== 1'b1)      $display("FAIL single_q cyc%0d: got %b want 1", c, bus8.q); else n_pass++;
    end
    tb_req = 4'b0000;
    tick();
    n_total++; if (bus8.gnt !== 4'b0000) $display("FAIL single_drop_gnt: got %b want 0000", bus8.gnt); else n_pass++;
    n_total++; if (bus8.busy !== 1'b0)   $display("FAIL single_drop_busy: got %b want 0", bus8.busy); else n_pass++;
    n_total++; if (bus8.sel !== 2'd2)    $display("FAIL single_sel_hold: got %0d want 2", bus8.sel); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp2 [15];
    logic [3:0] exp1 [8];
    exp2 = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0100,
             4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    exp1 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
    do_reset();
    tb_req = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      tick();
      n_total++; if (bus2.gnt !== exp2[c]) $display("FAIL rr_hold2_gnt cyc%0d: got %b want %b", c, bus2.gnt, exp2[c]); else n_pass++;
      if (c < 8) begin
        n_total++; if (bus1.gnt !== exp1[c]) $display("FAIL rr_hold1_gnt cyc%0d: got %b want %b", c, bus1.gnt, exp1[c]); else n_pass++;
      end
    end
  endtask

  task automatic test_burst_cap();
    logic [3:0] want;
    do_reset();
    tb_req = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      tick();
      want = (c == 9) ? 4'b0000 : 4'b0001;
      n_total++; if (bus8.gnt !== want) $display("FAIL burst_gnt cyc%0d: got %b want %b", c, bus8.gnt, want); else n_pass++;
      n_total++; if (bus8.busy !== |want) $display("FAIL burst_busy cyc%0d: got %b want %b", c, bus8.busy, |want); else n_pass++;
    end
    do_reset();
    tb_req = 4'b1000;
    tick();
    n_total++; if (bus8.gnt !== 4'b1000) $display("FAIL wrap_grant3: got %b want 1000", bus8.gnt); else n_pass++;
    tb_req = 4'b0001;
    tick();
    n_total++; if (bus8.gnt !== 4'b0000) $display("FAIL wrap_release: got %b want 0000", bus8.gnt); else n_pass++;
    tb_req = 4'b1001;
    tick();
    n_total++; if (bus8.gnt !== 4'b0001) $display("FAIL wrap_next_gnt: got %b want 0001", bus8.gnt); else n_pass++;
    n_total++; if (bus8.sel !== 2'd0)    $display("FAIL wrap_next_sel: got %0d want 0", bus8.sel); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    tb_req = 4'b0100;
    repeat (4) tick();
    n_total++; if (bus8.gnt !== 4'b0100) $display("FAIL midrst_pre_gnt: got %b want 0100", bus8.gnt); else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++; if (bus8.gnt !== 4'b0000) $display("FAIL midrst_gnt: got %b want 0000", bus8.gnt); else n_pass++;
    n_total++; if (bus8.busy !== 1'b0)   $display("FAIL midrst_busy: got %b want 0", bus8.busy); else n_pass++;
    n_total++; if (bus8.sel !== 2'd0)    $display("FAIL midrst_sel: got %0d want 0", bus8.sel); else n_pass++;
    tb_req = 4'b1111;
    tick();
    n_total++; if (bus8.gnt !== 4'b0001) $display("FAIL midrst_first_gnt: got %b want 0001", bus8.gnt); else n_pass++;
  endtask

  task automatic test_data_gating();
    do_reset();
    tb_in = 4'b1111;
    tick();
    n_total++; if (bus8.q !== 1'b0) $display("FAIL gate_idle_q: got %b want 0", bus8.q); else n_pass++;
    tb_req = 4'b0010;
    tb_in  = 4'b0010;
    tick();
    n_total++; if (bus8.sel !== 2'd1) $display("FAIL gate_sel: got %0d want 1", bus8.sel); else n_pass++;
    n_total++; if (bus8.q !== 1'b1)   $display("FAIL gate_q_hi: got %b want 1", bus8.q); else n_pass++;
    tb_in = 4'b0000;
    #1;
    n_total++; if (bus8.q !== 1'b0)   $display("FAIL gate_q_follow_lo: got %b want 0", bus8.q); else n_pass++;
    tb_in = 4'b0010;
    #1;
    n_total++; if (bus8.q !== 1'b1)   $display("FAIL gate_q_follow_hi: got %b want 1", bus8.q); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] eg;
    logic       eq;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) tb_req[b] = ~tb_req[b];
      reset = ($urandom_range(0, 49) == 0);
      tb_in = 4'($urandom);
      tick();
      for (int i = 0; i < 3; i++) begin
        eg = exp_gnt(m[i]);
        eq = (m[i].owner >= 0) ? tb_in[m[i].sel] : 1'b0;
        n_total++; if (o_gnt[i] !== eg) $display("FAIL rand_gnt inst%0d cyc%0d: got %b want %b", i, c, o_gnt[i], eg); else n_pass++;
        n_total++; if (o_sel[i] !== 2'(m[i].sel)) $display("FAIL rand_sel inst%0d cyc%0d: got %0d want %0d", i, c, o_sel[i], m[i].sel); else n_pass++;
        n_total++; if (o_busy[i] !== (m[i].owner >= 0)) $display("FAIL rand_busy inst%0d cyc%0d: got %b want %b", i, c, o_busy[i], m[i].owner >= 0); else n_pass++;
        n_total++; if (o_q[i] !== eq) $display("FAIL rand_q inst%0d cyc%0d: got %b want %b", i, c, o_q[i], eq); else n_pass++;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    tb_req = 4'b0000;
    tb_in  = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_reset_mid_burst();
    test_data_gating();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
